arbitro_memoria: RTL and testbench
==================================

Name: arbitro_memoria

Overview:
- Two-requester round-robin arbiter sharing the single 32-bit data-memory port between the fetch stage (requester 0) and the load/store stage (requester 1).
- Owns the `seletor` of the address and write-data 2:1 muxes in front of memory.
- Sequences each transaction: grant, hold, completion or timeout.
- Sits between the pipeline stages and data memory in the processor top level.

Parameters:
- TIMEOUT, 16, max cycles in BUSY waiting for `mem_ready` before aborting; legal range 2..255.
- CW, 8, width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0  input  1  request from requester 0; held high until `done0` or `erro0`
- req1  input  1  request from requester 1; same rule as `req0`
- endereco0  input  32  address from requester 0
- endereco1  input  32  address from requester 1
- dado0  input  32  write data from requester 0
- dado1  input  32  write data from requester 1
- escrita0  input  1  write enable from requester 0
- escrita1  input  1  write enable from requester 1
- mem_ready  input  1  memory completes the current access this cycle
- seletor  output  1  mux select; 0 selects requester 0, 1 selects requester 1
- mem_endereco  output  32  muxed address
- mem_dado  output  32  muxed write data
- mem_escrita  output  1  muxed write enable, gated by `mem_valid`
- mem_valid  output  1  access in progress
- gnt0  output  1  requester 0 owns the port
- gnt1  output  1  requester 1 owns the port
- done0  output  1  one-cycle completion pulse to requester 0
- done1  output  1  one-cycle completion pulse to requester 1
- erro0  output  1  one-cycle timeout pulse to requester 0
- erro1  output  1  one-cycle timeout pulse to requester 1

Behaviour:
- Reset values:
  - state = OCIOSO; seletor = 0; ultimo = 1, so requester 0 wins the first contest; contador = 0.
  - gnt0/1, mem_valid, done0/1 and erro0/1 are all 0.
  - Reset asserted mid-transaction aborts it immediately, with no `done` or `erro` pulse.
- States: OCIOSO and OCUPADO. All outputs are registered except `mem_endereco`, `mem_dado` and `mem_escrita`, which are combinational from `seletor`.
- OCIOSO:
  - Only req0 high: seletor <= 0, gnt0 <= 1, go to OCUPADO.
  - Only req1 high: seletor <= 1, gnt1 <= 1, go to OCUPADO.
  - Both high: grant the requester != ultimo.
  - Neither high: stay in OCIOSO.
- Latency: a request sampled at edge N gives gnt and mem_valid high from cycle N+1.
- OCUPADO:
  - mem_valid = 1; seletor and gnt are frozen; contador increments every cycle.
  - mem_ready = 1: pulse done<seletor> for the next cycle, clear gnt and mem_valid, set ultimo <= seletor, contador <= 0, go to OCIOSO.
  - mem_ready = 0 and contador == TIMEOUT-1: pulse erro<seletor> instead of done, with the same cleanup (ultimo is also updated). mem_ready in that same cycle takes priority over the timeout.
- Back-to-back transactions: OCIOSO lasts at least one cycle between transactions, so minimum throughput is one access per 2 cycles plus memory latency.
- Requester drop: if the granted req drops during OCUPADO, the transaction still completes; the protocol forbids the drop, and the bench flags it as a violation.
- Unused-port rules:
  - mem_escrita = mem_valid & (seletor ? escrita1 : escrita0).
  - mem_endereco and mem_dado pass through the mux even while idle; memory must ignore them when mem_valid = 0.
- Invariants: gnt0 & gnt1 is never 1; done and erro never pulse together.

Decomposition:
- Shared package: state encoding (OCIOSO = 1'b0, OCUPADO = 1'b1), requester index constants REQ0/REQ1, and the default TIMEOUT.
- Sub-module: two instances of the existing 32-bit `mux2x1`, one for the address and one for the write data, both driven by `seletor`.
- The write-enable mux is inline logic.

Test Plan:
- Reset then single request: reset pulse, then req0 = 1, endereco0 = 0x00000040, escrita0 = 0, mem_ready high on the 3rd OCUPADO cycle.
  - gnt0 = 1 and mem_endereco = 0x40 from cycle N+1.
  - done0 pulses once; seletor = 0 throughout.
- Contention and fairness: req0 and req1 held high together, mem_ready = 1 every OCUPADO cycle.
  - Grants alternate 0, 1, 0, 1.
  - gnt0 and gnt1 are never both high.
- Write routing: req1 = 1, endereco1 = 0x100, dado1 = 0xDEADBEEF, escrita1 = 1.
  - mem_escrita = 1, mem_dado = 0xDEADBEEF, seletor = 1.
  - mem_escrita = 0 once back in OCIOSO.
- Timeout: req0 = 1 with mem_ready held 0.
  - erro0 pulses after exactly 16 OCUPADO cycles; no done0.
  - A pending req1 is served next.
- Tie at the timeout boundary: mem_ready = 1 in the same cycle contador == 15.
  - done0 pulses; erro0 stays 0.
- Reset mid-operation: assert reset on the 2nd OCUPADO cycle.
  - All outputs return to reset values asynchronously; no done or erro pulse.
  - After reset, req1 alone is granted normally.

Source files
------------

// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the data-memory port arbiter: state encoding,
// requester indices and the round-robin pick between two requesters.
package arbitro_memoria_pkg;

    typedef enum logic {
        OCIOSO  = 1'b0,
        OCUPADO = 1'b1
    } estado_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int TIMEOUT_PADRAO = 16;

    // On a tie the requester that was not served last wins.
    function automatic logic escolhe(input logic r0, input logic r1, input logic ultimo);
        if (r0 && r1) begin
            return ~ultimo;
        end else if (r1) begin
            return REQ1;
        end else begin
            return REQ0;
        end
    endfunction

endpackage

// File: rtl/arbitro_memoria_mux2x1.sv
// 32-bit 2:1 multiplexer used for the memory address and write-data paths.
module mux2x1 (
    input  logic [31:0] entrada0,
    input  logic [31:0] entrada1,
    input  logic        seletor,
    output logic [31:0] saida
);

    assign saida = seletor ? entrada1 : entrada0;

endmodule

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter giving fetch (requester 0) and load/store (requester 1)
// turns on the single data-memory port, with completion and timeout handling.
//
//   state   | meaning
//   OCIOSO  | port free, waiting for a request
//   OCUPADO | access in flight, waiting for mem_ready or timeout
module arbitro_memoria
    import arbitro_memoria_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_PADRAO,
    parameter int CW      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] endereco0,
    input  logic [31:0] endereco1,
    input  logic [31:0] dado0,
    input  logic [31:0] dado1,
    input  logic        escrita0,
    input  logic        escrita1,
    input  logic        mem_ready,
    output logic        seletor,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_dado,
    output logic        mem_escrita,
    output logic        mem_valid,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        erro0,
    output logic        erro1
);

    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT - 1);

    estado_t       estado, estado_prox;
    logic          seletor_prox;
    logic          ultimo, ultimo_prox;
    logic [CW-1:0] contador, contador_prox;
    logic          gnt0_prox, gnt1_prox;
    logic          valid_prox;
    logic          done0_prox, done1_prox;
    logic          erro0_prox, erro1_prox;
    logic          vencedor;
    logic          fim_prazo;
    logic          encerra;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            seletor   <= REQ0;
            ultimo    <= REQ1;
            contador  <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            mem_valid <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            erro0     <= 1'b0;
            erro1     <= 1'b0;
        end else begin
            estado    <= estado_prox;
            seletor   <= seletor_prox;
            ultimo    <= ultimo_prox;
            contador  <= contador_prox;
            gnt0      <= gnt0_prox;
            gnt1      <= gnt1_prox;
            mem_valid <= valid_prox;
            done0     <= done0_prox;
            done1     <= done1_prox;
            erro0     <= erro0_prox;
            erro1     <= erro1_prox;
        end
    end

    always_comb begin
        estado_prox   = estado;
        seletor_prox  = seletor;
        ultimo_prox   = ultimo;
        contador_prox = contador;
        gnt0_prox     = gnt0;
        gnt1_prox     = gnt1;
        valid_prox    = mem_valid;
        done0_prox    = 1'b0;
        done1_prox    = 1'b0;
        erro0_prox    = 1'b0;
        erro1_prox    = 1'b0;
        vencedor      = escolhe(req0, req1, ultimo);
        fim_prazo     = (contador == LIMITE);
        encerra       = mem_ready || fim_prazo;

        case (estado)
            OCIOSO: begin
                if (req0 || req1) begin
                    seletor_prox  = vencedor;
                    gnt0_prox     = (vencedor == REQ0);
                    gnt1_prox     = (vencedor == REQ1);
                    valid_prox    = 1'b1;
                    contador_prox = '0;
                    estado_prox   = OCUPADO;
                end
            end
            OCUPADO: begin
                if (encerra) begin
                    // mem_ready wins over a timeout landing on the same cycle
                    done0_prox    = mem_ready && (seletor == REQ0);
                    done1_prox    = mem_ready && (seletor == REQ1);
                    erro0_prox    = !mem_ready && (seletor == REQ0);
                    erro1_prox    = !mem_ready && (seletor == REQ1);
                    gnt0_prox     = 1'b0;
                    gnt1_prox     = 1'b0;
                    valid_prox    = 1'b0;
                    ultimo_prox   = seletor;
                    contador_prox = '0;
                    estado_prox   = OCIOSO;
                end else begin
                    contador_prox = contador + 1'b1;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    mux2x1 u_mux_endereco (
        .entrada0 (endereco0),
        .entrada1 (endereco1),
        .seletor  (seletor),
        .saida    (mem_endereco)
    );

    mux2x1 u_mux_dado (
        .entrada0 (dado0),
        .entrada1 (dado1),
        .seletor  (seletor),
        .saida    (mem_dado)
    );

    assign mem_escrita = mem_valid & (seletor ? escrita1 : escrita0);

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria: table of transactions with a
// grant scoreboard, plus hand sequences for reset and idle behaviour.
module tb_arbitro_memoria;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0, req1;
    logic [31:0] endereco0, endereco1, dado0, dado1;
    logic        escrita0, escrita1, mem_ready;
    logic        seletor, mem_escrita, mem_valid;
    logic [31:0] mem_endereco, mem_dado;
    logic        gnt0, gnt1, done0, done1, erro0, erro1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        r0, r1, e0, e1;
        logic [31:0] a0, a1, d0, d1;
        int          lat;      // OCUPADO cycle carrying mem_ready; 0 = never
        logic        sel;
        logic        escrita;
    } vetor_t;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] dado;
        logic        escrita;
        logic        erro;
    } esperado_t;

    esperado_t fila[$];
    vetor_t    tabela[11];

    arbitro_memoria #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .endereco0    (endereco0),
        .endereco1    (endereco1),
        .dado0        (dado0),
        .dado1        (dado1),
        .escrita0     (escrita0),
        .escrita1     (escrita1),
        .mem_ready    (mem_ready),
        .seletor      (seletor),
        .mem_endereco (mem_endereco),
        .mem_dado     (mem_dado),
        .mem_escrita  (mem_escrita),
        .mem_valid    (mem_valid),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .done0        (done0),
        .done1        (done1),
        .erro0        (erro0),
        .erro1        (erro1)
    );

    always #5 clock = ~clock;

    task automatic verifica1(input string nome, input logic obtido, input logic esperado);
        n_cmp++;
        if (obtido !== esperado) begin
            n_err++;
            $display("FAIL %s: got=%0b expected=%0b at %0t", nome, obtido, esperado, $time);
        end
    endtask

    task automatic verifica32(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        n_cmp++;
        if (obtido !== esperado) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nome, obtido, esperado, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Invariants plus the requester-drop protocol check, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            verifica1("exclusao_gnt", gnt0 & gnt1, 1'b0);
            verifica1("done_com_erro", (done0 | done1) & (erro0 | erro1), 1'b0);
            verifica1("protocolo_req0", gnt0 & ~req0, 1'b0);
            verifica1("protocolo_req1", gnt1 & ~req1, 1'b0);
        end
    end

    // Starts from a post-edge point with the arbiter idle (or in a done cycle).
    task automatic transacao(input vetor_t v);
        esperado_t e;
        int espera;
        req0      = v.r0;
        req1      = v.r1;
        escrita0  = v.e0;
        escrita1  = v.e1;
        endereco0 = v.a0;
        endereco1 = v.a1;
        dado0     = v.d0;
        dado1     = v.d1;
        e.sel     = v.sel;
        e.addr    = v.sel ? v.a1 : v.a0;
        e.dado    = v.sel ? v.d1 : v.d0;
        e.escrita = v.escrita;
        e.erro    = (v.lat == 0);
        fila.push_back(e);

        tick();
        espera = 1;
        while (!(gnt0 || gnt1) && espera < 4) begin
            tick();
            espera++;
        end
        e = fila.pop_front();
        if (!(gnt0 || gnt1)) begin
            verifica1("concessao_prazo", gnt0 | gnt1, 1'b1);
            req0 = 1'b0;
            req1 = 1'b0;
            return;
        end
        verifica32("latencia_gnt", espera, 32'd1);
        verifica1("seletor", seletor, e.sel);
        verifica1("gnt0", gnt0, !e.sel);
        verifica1("gnt1", gnt1, e.sel);
        verifica1("mem_valid", mem_valid, 1'b1);
        verifica32("mem_endereco", mem_endereco, e.addr);
        verifica32("mem_dado", mem_dado, e.dado);
        verifica1("mem_escrita", mem_escrita, e.escrita);
        verifica1("pulso_anterior", done0 | done1 | erro0 | erro1, 1'b0);

        if (v.lat == 0) begin
            for (int i = 1; i < TIMEOUT; i++) begin
                tick();
                verifica1("pulso_cedo", done0 | done1 | erro0 | erro1, 1'b0);
                verifica1("ocupado", mem_valid, 1'b1);
            end
            tick();
        end else begin
            for (int i = 1; i < v.lat; i++) begin
                tick();
                verifica1("pulso_cedo", done0 | done1 | erro0 | erro1, 1'b0);
                verifica1("ocupado", mem_valid, 1'b1);
            end
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end

        verifica1("done0", done0, !e.erro && !e.sel);
        verifica1("done1", done1, !e.erro && e.sel);
        verifica1("erro0", erro0, e.erro && !e.sel);
        verifica1("erro1", erro1, e.erro && e.sel);
        verifica1("gnt_fim", gnt0 | gnt1, 1'b0);
        verifica1("valid_fim", mem_valid, 1'b0);
        verifica1("escrita_fim", mem_escrita, 1'b0);
        if (e.sel) req1 = 1'b0;
        else       req0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            r0    r1    e0    e1    a0            a1            d0            d1            lat sel   escrita
        tabela[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0080, 32'h1111_1111, 32'h2222_2222, 3,  1'b0, 1'b0};
        tabela[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0000_0100, 32'h3333_3333, 32'hDEAD_BEEF, 2,  1'b1, 1'b1};
        tabela[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0300, 32'hA000_0001, 32'hB000_0001, 1,  1'b0, 1'b0};
        tabela[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'h0000_0304, 32'hA000_0002, 32'hB000_0002, 1,  1'b1, 1'b1};
        tabela[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h0000_0308, 32'hA000_0003, 32'hB000_0003, 1,  1'b0, 1'b1};
        tabela[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_020C, 32'h0000_030C, 32'hA000_0004, 32'hB000_0004, 1,  1'b1, 1'b0};
        tabela[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0500, 32'hC000_0000, 32'hD000_0000, 0,  1'b0, 1'b0};
        tabela[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'h0000_0504, 32'hC000_0001, 32'hD000_0001, 2,  1'b1, 1'b0};
        tabela[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 32'h0000_0700, 32'hE000_0000, 32'hF000_0000, 16, 1'b0, 1'b0};
        tabela[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0604, 32'h0000_0704, 32'hE000_0001, 32'hF000_0001, 1,  1'b1, 1'b0};
        tabela[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_0708, 32'hCAFE_F00D, 32'hF000_0002, 4,  1'b0, 1'b1};

        req0 = 1'b0; req1 = 1'b0; escrita0 = 1'b0; escrita1 = 1'b0;
        endereco0 = '0; endereco1 = '0; dado0 = '0; dado1 = '0; mem_ready = 1'b0;

        tick();
        tick();
        verifica1("rst_seletor", seletor, 1'b0);
        verifica1("rst_gnt", gnt0 | gnt1, 1'b0);
        verifica1("rst_valid", mem_valid, 1'b0);
        verifica1("rst_pulsos", done0 | done1 | erro0 | erro1, 1'b0);
        reset = 1'b0;

        // Idle: muxes pass requester 0 through, write enable stays gated.
        endereco0 = 32'h0000_0040;
        endereco1 = 32'h0000_0100;
        escrita0  = 1'b1;
        tick();
        tick();
        verifica32("ocioso_endereco", mem_endereco, 32'h0000_0040);
        verifica1("ocioso_escrita", mem_escrita, 1'b0);
        verifica1("ocioso_gnt", gnt0 | gnt1, 1'b0);
        escrita0 = 1'b0;

        for (int k = 0; k < 11; k++) begin
            transacao(tabela[k]);
        end

        // Reset on the 2nd OCUPADO cycle aborts the access without pulses.
        tick();
        req0      = 1'b1;
        endereco0 = 32'h0000_0888;
        tick();
        verifica1("pre_rst_gnt0", gnt0, 1'b1);
        tick();
        #2 reset = 1'b1;
        #1;
        verifica1("rst_async_gnt0", gnt0, 1'b0);
        verifica1("rst_async_valid", mem_valid, 1'b0);
        verifica1("rst_async_seletor", seletor, 1'b0);
        verifica1("rst_async_pulsos", done0 | done1 | erro0 | erro1, 1'b0);
        tick();
        reset = 1'b0;
        req0  = 1'b0;
        tick();
        verifica1("pos_rst_pulsos", done0 | done1 | erro0 | erro1, 1'b0);

        // ultimo back at 1 after reset, so requester 0 wins the tie.
        transacao('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0900, 32'h0000_0A00,
                    32'h0000_0001, 32'h0000_0002, 2, 1'b0, 1'b0});
        transacao('{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0904, 32'h0000_0A04,
                    32'h0000_0003, 32'h0000_0004, 1, 1'b1, 1'b1});
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
